ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage of the 5-stage pipeline.
- Consumes the post-forwarding EX operands, i.e. the ALU source values after the ForwardA/ForwardB muxes.
- Holds the pipeline via a stall request while it iterates.
- Presents a 32-bit result to the EX/MEM register in its DONE cycle.
- Covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.

Parameters:
XLEN, 32, operand/result width
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  EX instruction is a valid M-extension op (decoder valid & not bubble)
flush  input  1  EX-stage flush (branch/jump redirect); synchronous
op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
src_a  input  XLEN  forwarded rs1 value
src_b  input  XLEN  forwarded rs2 value
stall  output  1  freeze PC, IF/ID, ID/EX; bubble into EX/MEM
busy  output  1  state != IDLE
done  output  1  result valid this cycle
result  output  XLEN  operation result

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, all internal regs 0. Outputs: done=0, busy=0, result=0. stall follows its combinational equation, which evaluates to start in IDLE.
- States: IDLE, CALC, DONE.
- stall = (state==IDLE & start & ~flush) | (state==CALC). Combinational.
- done = (state==DONE). result is registered and held stable through DONE.
- IDLE, start=1, flush=0:
  - Latch op and sign flags.
  - Latch operand magnitudes: signed ops take the absolute value; MULHSU takes the absolute value of src_a only.
  - Check special cases first. If any applies, load result and go to DONE (latency 1).
  - Otherwise go to CALC with counter=0.
- Special cases (div/rem only):
  - src_b==0: DIV/DIVU quotient=0xFFFFFFFF; REM/REMU = src_a.
  - Signed overflow (src_a=0x80000000, src_b=0xFFFFFFFF, DIV/REM): quotient=0x80000000, rem=0.
- CALC: exactly 32 cycles, counter 0..31. Transition to DONE when counter==31.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring, 1 quotient bit per cycle. 33-bit partial remainder, borrow selects the quotient bit.
- Leaving CALC, apply sign correction:
  - Product negated if sign_a^sign_b, or sign_a for MULHSU.
  - Quotient negated if sign_a^sign_b.
  - Remainder takes the sign of the dividend.
  - MUL returns the low 32 bits; MULH* return the high 32 bits.
- Latency for the normal path: start sampled in cycle T gives stall in cycles T..T+32, done in T+33.
- DONE: stall=0, so the pipeline advances and EX/MEM captures result. start is ignored. Next state is IDLE unconditionally.
- Back-to-back M ops: the second op is seen in IDLE at T+34. No overlap.
- flush has priority in every state. Next state is IDLE; done never asserts for the flushed op; stall drops in the following cycle. In IDLE, flush with start does not begin an op.
- Reset mid-operation: aborts immediately, no done.
- Arithmetic is unsigned on magnitudes throughout. Overflow is defined only by the special cases above.

Decomposition:
- defines.vh gains:
  - MD_MUL..MD_REMU funct3 constants.
  - MD_IDLE/MD_CALC/MD_DONE state encodings.
  - The MD_DIV_ZERO_Q constant 0xFFFFFFFF.
- One natural sub-module, muldiv_sign_fix: combinational negate/select of product, quotient and remainder. Everything else stays in ex_muldiv_unit.

Test Plan:
- MUL 7 * 0xFFFFFFFD (-3), start at T -> stall T..T+32; done at T+33; result 0xFFFFFFEB.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each case has done at T+33.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0. For all four: stall only in cycle T, done at T+1.
- MUL started at T, flush=1 in T+10 -> busy=0 and stall=0 from T+11, done never asserts. A following DIVU 9/3 starting at T+12 -> result 3 at T+45.
- rst_n pulsed low at T+5 during a DIV -> outputs zero asynchronously, state IDLE; no done after reset release.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared constants for the EX-stage RV32M multiply/divide unit:
// funct3 op codes, FSM state encodings and the divide-by-zero quotient.
package ex_muldiv_unit_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_CALC = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

  localparam logic [31:0] MD_DIV_ZERO_Q = 32'hFFFF_FFFF;

  // src_a is treated as signed for every signed op, src_b only when both are signed
  function automatic logic signed_a(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic signed_b(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_sign_fix.sv
// Combinational sign correction and result select applied to the unsigned
// magnitude results of the iterative multiply/divide datapath.
module muldiv_sign_fix
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        i_op,
  input  logic              i_sign_a,
  input  logic              i_sign_b,
  input  logic [2*XLEN-1:0] i_prod,
  input  logic [XLEN-1:0]   i_quo,
  input  logic [XLEN-1:0]   i_rem,
  output logic [XLEN-1:0]   o_result
);

  logic              w_prod_neg;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;

  // MULHSU has an unsigned rs2, so only the sign of rs1 decides the product sign
  assign w_prod_neg = (i_op == MD_MULHSU) ? i_sign_a : (i_sign_a ^ i_sign_b);
  assign w_prod_fix = w_prod_neg ? (~i_prod + 1'b1) : i_prod;
  assign w_quo_fix  = (i_sign_a ^ i_sign_b) ? (~i_quo + 1'b1) : i_quo;
  assign w_rem_fix  = i_sign_a ? (~i_rem + 1'b1) : i_rem;

  always_comb begin
    o_result = '0;
    case (i_op)
      MD_MUL:                     o_result = w_prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: o_result = w_prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:            o_result = w_quo_fix;
      default:                    o_result = w_rem_fix;
    endcase
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage; stalls the pipeline
// while it runs 32 shift-add / restoring-divide steps on operand magnitudes.
//   state   | meaning
//   IDLE    | waiting for an M op; special div cases resolve here in one cycle
//   CALC    | 32 iterations, counter 0..31
//   DONE    | result valid for EX/MEM, stall released
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic              r_sign_a;
  logic              r_sign_b;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_result;

  logic              w_sign_a;
  logic              w_sign_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_is_div;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic [XLEN-1:0]   w_special;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic              w_borrow;
  logic [XLEN-1:0]   w_rem_nxt;
  logic [XLEN-1:0]   w_quo_nxt;
  logic              w_last;
  logic [XLEN-1:0]   w_fixed;

  assign w_sign_a = signed_a(op) & src_a[XLEN-1];
  assign w_sign_b = signed_b(op) & src_b[XLEN-1];
  assign w_mag_a  = w_sign_a ? (~src_a + 1'b1) : src_a;
  assign w_mag_b  = w_sign_b ? (~src_b + 1'b1) : src_b;

  assign w_is_div   = op[2];
  assign w_div_zero = w_is_div && (src_b == '0);
  assign w_div_ovf  = ((op == MD_DIV) || (op == MD_REM)) &&
                      (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);

  always_comb begin
    w_special = '0;
    if (w_div_zero) w_special = op[1] ? src_a : MD_DIV_ZERO_Q;
    else if (w_div_ovf) w_special = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // multiplier sits in the low half of the accumulator and shifts out LSB-first
  assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_a : '0)};
  assign w_acc_nxt = {w_sum, r_acc[XLEN-1:1]};

  // r_rem < r_b always, so a set bit XLEN of the 33-bit difference means borrow
  assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_b};
  assign w_borrow  = w_diff[XLEN];
  assign w_rem_nxt = w_borrow ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], ~w_borrow};

  assign w_last = (r_cnt == CNT_W'(XLEN-1));

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .i_op     (r_op),
    .i_sign_a (r_sign_a),
    .i_sign_b (r_sign_b),
    .i_prod   (w_acc_nxt),
    .i_quo    (w_quo_nxt),
    .i_rem    (w_rem_nxt),
    .o_result (w_fixed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= MD_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_result <= '0;
    end else if (flush) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (start) begin
            r_op     <= op;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_a      <= w_mag_a;
            r_b      <= w_mag_b;
            r_acc    <= {{XLEN{1'b0}}, w_mag_b};
            r_quo    <= w_mag_a;
            r_rem    <= '0;
            r_cnt    <= '0;
            if (w_div_zero || w_div_ovf) begin
              r_result <= w_special;
              r_state  <= MD_DONE;
            end else begin
              r_state  <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          if (r_op[2]) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
          end else begin
            r_acc <= w_acc_nxt;
          end
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_result <= w_fixed;
            r_state  <= MD_DONE;
          end
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign stall  = ((r_state == MD_IDLE) && start && !flush) || (r_state == MD_CALC);
  assign busy   = (r_state != MD_IDLE);
  assign done   = (r_state == MD_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: table of ops with hand-computed results
// and latencies, plus flush and mid-operation reset sequences.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  ex_muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drives one op in the next IDLE cycle T; checks stall in T, no stall gap,
  // done latency relative to T and the result.
  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int  k;
    int  gaps;
    bit  seen;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    #1;
    chk({nm, "_stall_T"}, 32'(stall), 32'd1);
    @(posedge clk);
    k = 0;
    gaps = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      start = 1'b0;
      k++;
      #1;
      if (done) seen = 1'b1;
      else if (!stall) gaps++;
    end
    if (!seen) k = -1;
    chk({nm, "_latency"}, 32'(k), 32'(lat));
    chk({nm, "_result"}, result, exp);
    chk({nm, "_stall_gap"}, 32'(gaps), 32'd0);
    chk({nm, "_stall_done"}, 32'(stall), 32'd0);
  endtask

  initial begin
    int dseen;

    vecs[0]  = '{MD_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{MD_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 33};
    vecs[2]  = '{MD_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[3]  = '{MD_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[4]  = '{MD_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{MD_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{MD_DIVU,   32'd100,        32'd7,        32'd14,       33};
    vecs[7]  = '{MD_REMU,   32'd100,        32'd7,        32'd2,        33};
    vecs[8]  = '{MD_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{MD_REMU,   32'd5,          32'd0,        32'd5,        1};
    vecs[10] = '{MD_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{MD_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        1};
    vecs[12] = '{MD_DIV,    32'hFFFFFFF9,   32'd0,        32'hFFFFFFFF, 1};
    vecs[13] = '{MD_REM,    32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9, 1};
    vecs[14] = '{MD_MUL,    32'h00010000,   32'h00010000, 32'd0,        33};
    vecs[15] = '{MD_MULHU,  32'h00010000,   32'h00010000, 32'd1,        33};
    vecs[16] = '{MD_DIV,    32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[17] = '{MD_REM,    32'd7,          32'hFFFFFFFE, 32'd1,        33};

    rst_n = 1'b0;
    start = 1'b1;
    flush = 1'b0;
    op    = MD_MUL;
    src_a = '0;
    src_b = '0;
    #12;
    chk("reset_done",   32'(done),   32'd0);
    chk("reset_busy",   32'(busy),   32'd0);
    chk("reset_result", result,      32'd0);
    chk("reset_stall",  32'(stall),  32'd1);
    start = 1'b0;
    #1;
    chk("reset_stall_idle", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // flush in T+10 of a MUL; a DIVU follows at T+12
    @(negedge clk);
    start = 1'b1;
    op    = MD_MUL;
    src_a = 32'd5;
    src_b = 32'd6;
    @(posedge clk);
    dseen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) flush = 1'b1;
      #1;
      if (done) dseen++;
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    if (done) dseen++;
    chk("flush_busy",  32'(busy),  32'd0);
    chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_no_done", 32'(dseen), 32'd0);
    run_op("after_flush_divu", MD_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // asynchronous reset in T+5 of a DIV
    @(negedge clk);
    start = 1'b1;
    op    = MD_DIV;
    src_a = 32'd100;
    src_b = 32'd7;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midop_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midop_rst_done",   32'(done),  32'd0);
    chk("midop_rst_busy",   32'(busy),  32'd0);
    chk("midop_rst_stall",  32'(stall), 32'd0);
    chk("midop_rst_result", result,     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dseen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (done || busy) dseen++;
    end
    chk("midop_no_done", 32'(dseen), 32'd0);
    run_op("after_reset_remu", MD_REMU, 32'd100, 32'd7, 32'd2, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
